// File: rtl/period_meter.sv
// Measures sig_in period and high time in clock cycles, one measurement per start request.
// Result is valid 2-3 cycles after the terminating edge; start is ignored while busy or during done.
module period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt;
  logic             sat;
  logic             fall_seen;
  logic             accept;
  logic             finish;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign sat  = (cnt == MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // done is high in the first IDLE cycle; a start there is dropped
        if (start && !done) begin
          state_nxt = ARM;
          accept    = 1'b1;
        end
      end
      ARM: begin
        if (rise)     state_nxt = MEASURE;
        else if (sat) state_nxt = IDLE;
      end
      MEASURE: begin
        if (rise || sat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    finish = (state != IDLE) && (state_nxt == IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      cnt       <= '0;
      fall_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      period    <= '0;
      high_time <= '0;
    end else begin
      s1   <= sig_in;
      s2   <= s1;
      s3   <= s2;
      busy <= (state_nxt != IDLE);
      done <= finish;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            fall_seen <= 1'b0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        ARM: begin
          // a level already high at arming gives no rise, so it is never counted
          if (rise) begin
            cnt <= ONE;
          end else if (sat) begin
            period    <= MAX;
            high_time <= MAX;
            overflow  <= 1'b1;
            valid     <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        MEASURE: begin
          if (fall) begin
            high_time <= cnt;
            fall_seen <= 1'b1;
          end
          // rise takes priority over saturation: a max-length period is not an overflow
          if (rise) begin
            period <= cnt;
            valid  <= 1'b1;
          end else if (sat) begin
            period   <= MAX;
            overflow <= 1'b1;
            valid    <= 1'b1;
            if (!fall_seen && !fall) high_time <= MAX;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: 16-bit instance for normal measurements, 8-bit instance for overflow.
module tb_period_meter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sig16 = 1'b0;
  logic        start16 = 1'b0;
  logic        busy16, done16, valid16, ovf16;
  logic [15:0] period16, high16;
  logic        sig8 = 1'b0;
  logic        start8 = 1'b0;
  logic        busy8, done8, valid8, ovf8;
  logic [7:0]  period8, high8;

  int checks = 0;
  int errors = 0;
  int done_cnt16 = 0;
  int done_cnt8 = 0;
  int base;

  always #5 clock = ~clock;

  period_meter #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .sig_in(sig16), .start(start16),
    .busy(busy16), .done(done16), .valid(valid16),
    .period(period16), .high_time(high16), .overflow(ovf16)
  );

  period_meter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .sig_in(sig8), .start(start8),
    .busy(busy8), .done(done8), .valid(valid8),
    .period(period8), .high_time(high8), .overflow(ovf8)
  );

  always @(negedge clock) begin
    if (done16) done_cnt16++;
    if (done8)  done_cnt8++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // n periods of 'per' cycles, high for the first 'hi'; toggles start during the first 'spam' cycles
  task automatic wave16(input int per, input int hi, input int n, input int spam);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < per; i++) begin
        sig16 = (i < hi);
        if (spam > 0) start16 = ((p * per + i) < spam) && (((p * per + i) % 2) == 1);
        tick();
      end
    end
    sig16 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done16(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (done16) ok = 1'b1;
    end
  endtask

  task automatic pulse_start16();
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;

    ticks(3);
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_valid", valid16, 0);
    check("rst_period", period16, 0);
    check("rst_high", high16, 0);
    check("rst_ovf", ovf16, 0);
    reset = 1'b1;
    ticks(3);
    check("idle_busy", busy16, 0);

    // 10-cycle period, 3 high; restart attempted in the done cycle and the one after
    base = done_cnt16;
    pulse_start16();
    check("t1_busy", busy16, 1);
    fork
      wave16(10, 3, 4, 0);
      begin
        wait_done16(40, ok);
        check("t1_done_seen", ok, 1);
        check("t1_period", period16, 10);
        check("t1_high", high16, 3);
        check("t1_valid", valid16, 1);
        check("t1_ovf", ovf16, 0);
        check("t1_busy_at_done", busy16, 0);
        start16 = 1'b1;
        tick();
        check("t1_start_in_done_ignored", busy16, 0);
        check("t1_valid_held", valid16, 1);
        tick();
        start16 = 1'b0;
        check("t1_start_after_done", busy16, 1);
        check("t1_valid_cleared", valid16, 0);
        wait_done16(40, ok);
        check("t1_done2_seen", ok, 1);
        check("t1_period2", period16, 10);
        check("t1_high2", high16, 3);
      end
    join
    ticks(3);
    check("t1_done_count", done_cnt16 - base, 2);

    // 1000-cycle period, 50% duty
    base = done_cnt16;
    pulse_start16();
    wave16(1000, 500, 2, 0);
    ticks(5);
    check("t2_done_count", done_cnt16 - base, 1);
    check("t2_period", period16, 1000);
    check("t2_high", high16, 500);
    check("t2_ovf", ovf16, 0);

    // 8-bit instance with sig_in stuck low saturates
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    ok = 1'b0;
    while (n < 400 && !ok) begin
      tick();
      n++;
      if (done8) ok = 1'b1;
    end
    check("t3_done_seen", ok, 1);
    check("t3_latency_range", (n >= 255 && n <= 257), 1);
    check("t3_ovf", ovf8, 1);
    check("t3_period", period8, 255);
    check("t3_high", high8, 255);
    check("t3_valid", valid8, 1);
    check("t3_busy", busy8, 0);
    ticks(3);
    check("t3_done_count", done_cnt8, 1);

    // sig_in already high at start: the stale high phase is not measured
    base = done_cnt16;
    sig16 = 1'b1;
    ticks(6);
    pulse_start16();
    ticks(3);
    check("t4_busy_armed", busy16, 1);
    sig16 = 1'b0;
    ticks(6);
    wave16(20, 5, 2, 0);
    ticks(5);
    check("t4_done_count", done_cnt16 - base, 1);
    check("t4_period", period16, 20);
    check("t4_high", high16, 5);

    // repeated start pulses while busy
    base = done_cnt16;
    pulse_start16();
    wave16(12, 4, 2, 10);
    ticks(5);
    check("t5_done_count", done_cnt16 - base, 1);
    check("t5_period", period16, 12);
    check("t5_high", high16, 4);
    check("t5_busy", busy16, 0);

    // reset in the middle of MEASURE
    base = done_cnt16;
    pulse_start16();
    sig16 = 1'b1;
    ticks(4);
    sig16 = 1'b0;
    ticks(3);
    check("t6_busy_before", busy16, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_busy", busy16, 0);
    check("t6_rst_valid", valid16, 0);
    check("t6_rst_period", period16, 0);
    check("t6_rst_high", high16, 0);
    check("t6_rst_ovf", ovf16, 0);
    check("t6_rst_done", done16, 0);
    ticks(2);
    reset = 1'b1;
    ticks(10);
    check("t6_no_done", done_cnt16 - base, 0);
    check("t6_idle", busy16, 0);
    pulse_start16();
    wave16(8, 2, 2, 0);
    ticks(5);
    check("t6_done_count", done_cnt16 - base, 1);
    check("t6_period", period16, 8);
    check("t6_high", high16, 2);
    check("t6_valid", valid16, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
